approx_cmp_err_monitor: RTL



---
 rtl/approx_cmp_err_monitor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/approx_cmp_err_monitor.sv
// Windowed mismatch/illegal-output counter for the approximate comparator.
// Define APPROX_MON_ILLEGAL_EN to enable the illegal_count datapath.
module approx_cmp_err_monitor #(
    parameter int WIDTH    = 4,
    parameter int WIN_LOG2 = 4,
    parameter int CNT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    output logic             win_valid,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << WIN_LOG2) - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] acc_err;
    logic [CNT_W-1:0] acc_err_nxt;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_dec;
    logic             s1_vld;
    logic [2:0]       exact;
    logic             err_hit;
    logic             xfer;

    assign in_ready = (state == ACCUM) & ~rst;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        exact = 3'b001;
        if (s1_a == s1_b)
            exact = 3'b100;
        else if (s1_a > s1_b)
            exact = 3'b010;
    end

    assign err_hit     = s1_vld & (s1_dec != exact);
    assign acc_err_nxt = acc_err + CNT_W'(err_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            smp_cnt   <= '0;
            acc_err   <= '0;
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_dec    <= '0;
            win_valid <= 1'b0;
            err_count <= '0;
        end else begin
            s1_vld    <= xfer;
            win_valid <= 1'b0;
            if (xfer) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_dec  <= {eq, gt, lt};
                smp_cnt <= smp_cnt + 1'b1;
            end
            case (state)
                ACCUM: begin
                    acc_err <= acc_err_nxt;
                    if (xfer && smp_cnt == WIN_LAST)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // The window's last sample lands in the report directly.
                    acc_err   <= acc_err_nxt;
                    err_count <= acc_err_nxt;
                    win_valid <= 1'b1;
                    state     <= REPORT;
                end
                REPORT: begin
                    smp_cnt <= '0;
                    acc_err <= '0;
                    state   <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef APPROX_MON_ILLEGAL_EN
    logic [CNT_W-1:0] acc_ill;
    logic [CNT_W-1:0] acc_ill_nxt;
    logic             ill_hit;
    logic [CNT_W-1:0] ill_q;

    assign ill_hit     = s1_vld & ~(s1_dec inside {3'b100, 3'b010, 3'b001});
    assign acc_ill_nxt = acc_ill + CNT_W'(ill_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_ill <= '0;
            ill_q   <= '0;
        end else begin
            case (state)
                FLUSH: begin
                    acc_ill <= acc_ill_nxt;
                    ill_q   <= acc_ill_nxt;
                end
                REPORT:  acc_ill <= '0;
                default: acc_ill <= acc_ill_nxt;
            endcase
        end
    end

    assign illegal_count = ill_q;
`else
    assign illegal_count = '0;
`endif

endmodule
